// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared FSM state type, instruction width and wait-time helper for the SPI register sequencer
package spi_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} seq_state_t;
  localparam int INSTR_WIDTH = 8;
  function automatic int seq_wait_cycles(input int l, input int cpb, input int guard);
    return l * cpb + guard;
  endfunction
endpackage

// File: rtl/spi_register_sequencer_packer.sv
// spi_transaction_packer: builds right-aligned {rw, addr, wdata} data and rw mask (rw, addr, wdata in; data, mask out)
module spi_transaction_packer
  import spi_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 7,
  parameter int REG_DATA_WIDTH = 16
) (
  input  logic                      rw,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [REG_DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0]     data,
  output logic [DATA_WIDTH-1:0]     mask
);
  localparam int L = INSTR_WIDTH + REG_DATA_WIDTH;
  localparam int W = L > DATA_WIDTH ? L : DATA_WIDTH;
  logic [W-1:0] d, m;
  always_comb begin
    d = '0;
    m = '0;
    d[L-1:0] = {rw, addr, rw ? {REG_DATA_WIDTH{1'b0}} : wdata};
    m[L-1 -: INSTR_WIDTH] = '1;
    m[REG_DATA_WIDTH-1:0] = {REG_DATA_WIDTH{!rw}};
  end
  assign data = d[DATA_WIDTH-1:0];
  assign mask = m[DATA_WIDTH-1:0];
endmodule

// File: rtl/spi_register_sequencer.sv
// spi_register_sequencer: register cmd port -> one-shot SPI transaction -> timed response (cmd/rsp valid-ready, transaction_* to core, busy, cfg_error)
module spi_register_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DATA_WIDTH            = 32,
  parameter int TRANSACTION_LEN_WIDTH = 8,
  parameter int ADDR_WIDTH            = 7,
  parameter int REG_DATA_WIDTH        = 16,
  parameter int CYCLES_PER_BIT        = 8,
  parameter int GUARD_CYCLES          = 32
) (
  input  logic                             fabric_clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_rw,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [REG_DATA_WIDTH-1:0]        cmd_wdata,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [REG_DATA_WIDTH-1:0]        rsp_rdata,
  output logic                             rsp_rw,
  output logic [TRANSACTION_LEN_WIDTH-1:0] transaction_length,
  output logic [DATA_WIDTH-1:0]            transaction_data,
  output logic [DATA_WIDTH-1:0]            transaction_rw_mask,
  input  logic [DATA_WIDTH-1:0]            transaction_read_data,
  output logic                             busy,
  output logic                             cfg_error
);
  localparam int L = INSTR_WIDTH + REG_DATA_WIDTH;
  localparam int N = seq_wait_cycles(L, CYCLES_PER_BIT, GUARD_CYCLES);
  if (N > 65535 || N < 1) begin : g_bad_wait
    $error("wait count out of 16-bit counter range");
  end
  if (ADDR_WIDTH + 1 != INSTR_WIDTH) begin : g_bad_addr
    $error("address plus rw bit must fill the instruction byte");
  end
  seq_state_t state;
  logic [15:0] cnt;
  logic rw_q;
  logic [DATA_WIDTH-1:0] pk_data, pk_mask;
  logic unused_rdata;
  assign unused_rdata = ^transaction_read_data;
  assign cfg_error = L > DATA_WIDTH;
  assign cmd_ready = state == IDLE && !cfg_error;
  assign busy = state != IDLE;
  // Length is nonzero only in ISSUE so the core cannot retrigger while idle.
  assign transaction_length = state == ISSUE ? TRANSACTION_LEN_WIDTH'(L) : '0;
  spi_transaction_packer #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .REG_DATA_WIDTH(REG_DATA_WIDTH)
  ) u_packer (
    .rw(cmd_rw),
    .addr(cmd_addr),
    .wdata(cmd_wdata),
    .data(pk_data),
    .mask(pk_mask)
  );
  // Data and mask are captured with the command so they are valid during the ISSUE cycle and hold through WAIT.
  always_ff @(posedge fabric_clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rw_q <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_rw <= 1'b0;
      transaction_data <= '0;
      transaction_rw_mask <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid && cmd_ready) begin
          rw_q <= cmd_rw;
          transaction_data <= pk_data;
          transaction_rw_mask <= pk_mask;
          state <= ISSUE;
        end
        ISSUE: begin
          cnt <= 16'(N - 1);
          state <= WAIT;
        end
        WAIT: if (cnt == '0) begin
          rsp_rdata <= rw_q ? transaction_read_data[REG_DATA_WIDTH-1:0] : '0;
          rsp_rw <= rw_q;
          rsp_valid <= 1'b1;
          state <= RESP;
        end else begin
          cnt <= cnt - 16'd1;
        end
        default: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_register_sequencer.sv
// tb_spi_register_sequencer: directed self-checking bench for the SPI register sequencer
module tb_spi_register_sequencer;
  localparam int N = 224;
  logic fabric_clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_rw = 1'b0, rsp_ready = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic [31:0] transaction_read_data = 32'h0000A5C3;
  logic cmd_ready, rsp_valid, rsp_rw, busy, cfg_error;
  logic [15:0] rsp_rdata;
  logic [7:0] transaction_length;
  logic [31:0] transaction_data, transaction_rw_mask;
  logic c_cmd_valid = 1'b1;
  logic [31:0] c_wdata = 32'h12345678;
  logic c_ready, c_rsp_valid, c_rsp_rw, c_busy, c_err;
  logic [31:0] c_rdata, c_data, c_mask;
  logic [7:0] c_len;
  int checks = 0, passed = 0, cyc = 0, pulses = 0, last_pulse = 0, prev_pulse = 0, cfg_pulses = 0;
  always #5 fabric_clk = ~fabric_clk;
  spi_register_sequencer dut (
    .fabric_clk(fabric_clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_rw(rsp_rw),
    .transaction_length(transaction_length), .transaction_data(transaction_data),
    .transaction_rw_mask(transaction_rw_mask), .transaction_read_data(transaction_read_data),
    .busy(busy), .cfg_error(cfg_error)
  );
  spi_register_sequencer #(.REG_DATA_WIDTH(32)) dut_cfg (
    .fabric_clk(fabric_clk), .reset(reset), .cmd_valid(c_cmd_valid), .cmd_ready(c_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(c_wdata), .rsp_valid(c_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(c_rdata), .rsp_rw(c_rsp_rw),
    .transaction_length(c_len), .transaction_data(c_data),
    .transaction_rw_mask(c_mask), .transaction_read_data(transaction_read_data),
    .busy(c_busy), .cfg_error(c_err)
  );
  always @(posedge fabric_clk) cyc++;
  always @(negedge fabric_clk) begin
    if (transaction_length != 0) begin
      pulses++;
      prev_pulse = last_pulse;
      last_pulse = cyc;
    end
    if (c_len != 0) cfg_pulses++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge fabric_clk);
    #1;
  endtask
  task automatic send(input string tag, input logic rw, input logic [6:0] addr, input logic [15:0] wd,
                      input logic [31:0] exp_data, input logic [31:0] exp_mask);
    cmd_rw = rw;
    cmd_addr = addr;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    check({tag, "_ready"}, cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    cmd_wdata = 16'h5A5A;
    check({tag, "_len"}, transaction_length, 24);
    check({tag, "_data"}, transaction_data, exp_data);
    check({tag, "_mask"}, transaction_rw_mask, exp_mask);
    tick();
    check({tag, "_len_wait"}, transaction_length, 0);
    check({tag, "_data_hold"}, transaction_data, exp_data);
    check({tag, "_mask_hold"}, transaction_rw_mask, exp_mask);
  endtask
  task automatic wait_rsp(input string tag, input logic [15:0] exp_rdata, input logic exp_rw);
    repeat (N - 1) tick();
    check({tag, "_rsp_early"}, rsp_valid, 0);
    tick();
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_rsp_rw"}, rsp_rw, exp_rw);
  endtask
  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_idle"}, busy, 0);
    check({tag, "_rsp_clr"}, rsp_valid, 0);
  endtask
  initial begin
    int p;
    logic seen;
    repeat (3) tick();
    check("rst_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_rw", rsp_rw, 0);
    check("rst_len", transaction_length, 0);
    check("rst_data", transaction_data, 0);
    check("rst_mask", transaction_rw_mask, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    send("wr", 1'b0, 7'h12, 16'hBEEF, 32'h0012BEEF, 32'h00FFFFFF);
    wait_rsp("wr", 16'h0000, 1'b0);
    handshake("wr");
    send("rd", 1'b1, 7'h05, 16'hFFFF, 32'h00850000, 32'h00FF0000);
    wait_rsp("rd", 16'hA5C3, 1'b1);
    handshake("rd");
    transaction_read_data = 32'hFFFF1234;
    send("bp", 1'b1, 7'h33, 16'h0000, 32'h00B30000, 32'h00FF0000);
    wait_rsp("bp", 16'h1234, 1'b1);
    transaction_read_data = 32'h0000A5C3;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_rdata", rsp_rdata, 16'h1234);
      check("bp_hold_ready", cmd_ready, 0);
    end
    handshake("bp");
    check("bp_ready_back", cmd_ready, 1);
    p = pulses;
    rsp_ready = 1'b1;
    cmd_rw = 1'b0;
    cmd_addr = 7'h01;
    cmd_wdata = 16'h1234;
    cmd_valid = 1'b1;
    tick();
    check("b2b_first_data", transaction_data, 32'h00011234);
    cmd_rw = 1'b1;
    cmd_addr = 7'h7F;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      tick();
      seen = transaction_length != 0;
    end
    cmd_valid = 1'b0;
    check("b2b_second_issue", seen, 1);
    check("b2b_second_data", transaction_data, 32'h00FF0000);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      seen = rsp_valid;
    end
    check("b2b_second_rsp", seen, 1);
    check("b2b_second_rdata", rsp_rdata, 16'hA5C3);
    repeat (20) tick();
    rsp_ready = 1'b0;
    check("b2b_pulses", pulses - p, 2);
    check("b2b_spacing", last_pulse - prev_pulse, 227);
    send("rw", 1'b0, 7'h40, 16'h00FF, 32'h004000FF, 32'h00FFFFFF);
    repeat (48) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_busy", busy, 0);
    check("rw_ready", cmd_ready, 1);
    check("rw_len", transaction_length, 0);
    check("rw_data", transaction_data, 0);
    check("rw_mask", transaction_rw_mask, 0);
    check("rw_rsp_valid", rsp_valid, 0);
    p = pulses;
    seen = 1'b0;
    repeat (250) begin
      tick();
      seen = seen | rsp_valid;
    end
    check("rw_no_rsp", seen, 0);
    check("rw_no_pulse", pulses - p, 0);
    send("rw_after", 1'b1, 7'h05, 16'h0000, 32'h00850000, 32'h00FF0000);
    wait_rsp("rw_after", 16'hA5C3, 1'b1);
    handshake("rw_after");
    check("cfg_error", c_err, 1);
    check("cfg_ready", c_ready, 0);
    check("cfg_busy", c_busy, 0);
    check("cfg_pulses", cfg_pulses, 0);
    check("cfg_ok_default", cfg_error, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/spi_register_sequencer.md
# spi_register_sequencer

Upstream command stage for `bidirectional_spi`. It accepts register-level read/write commands on a valid/ready port and builds the 3-wire SPI transaction: an instruction byte (R/W bit plus 7-bit address) followed by a data field. It presents that transaction as a one-cycle `transaction_length` pulse with matching data and read/write mask, then waits a computed completion time. It then returns read data, or a write acknowledge, on a valid/ready response port.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of SPI-core transaction data and mask.
- `TRANSACTION_LEN_WIDTH`, 8: width of the `transaction_length` field.
- `ADDR_WIDTH`, 7: register address width. Instruction byte is `{rw, addr}`, so `ADDR_WIDTH` + 1 = 8.
- `REG_DATA_WIDTH`, 16: register payload width.
- `CYCLES_PER_BIT`, 8: `fabric_clk` cycles per SPI bit, matching the SPI-core clock divider.
- `GUARD_CYCLES`, 32: extra wait for CDC FIFOs, CS timing and read-back latency.

Ports:
- `fabric_clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_rw` in 1: 1 = read, 0 = write.
- `cmd_addr` in `ADDR_WIDTH`: register address.
- `cmd_wdata` in `REG_DATA_WIDTH`: write payload; ignored on reads.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumer ready.
- `rsp_rdata` out `REG_DATA_WIDTH`: read data; 0 for writes.
- `rsp_rw` out 1: echo of `cmd_rw`.
- `transaction_length` out `TRANSACTION_LEN_WIDTH`: to the SPI core.
- `transaction_data` out `DATA_WIDTH`: to the SPI core.
- `transaction_rw_mask` out `DATA_WIDTH`: to the SPI core.
- `transaction_read_data` in `DATA_WIDTH`: from the SPI core.
- `busy` out 1: high in any state other than IDLE.
- `cfg_error` out 1: constant, high when 8 + `REG_DATA_WIDTH` > `DATA_WIDTH`.

## Operation
State machine: IDLE, ISSUE, WAIT, RESP.

- **IDLE:**
  - `cmd_ready` = 1 when `cfg_error` = 0.
  - On `cmd_valid && cmd_ready`: latch `rw`, `addr`, `wdata`, then go to ISSUE.
- **ISSUE (exactly one cycle):**
  - `transaction_length` = L = 8 + `REG_DATA_WIDTH`.
  - `transaction_data` = `{rw, addr, wdata}`, right-aligned with the instruction MSB at bit L-1; upper bits 0. For a read, `wdata` is replaced by 0.
  - `transaction_rw_mask`: bits [L-1 : L-8] = 1. Bits [L-9 : 0] = 1 for a write, 0 for a read. Upper bits 0.
  - Load the wait counter with N-1, where N = L·`CYCLES_PER_BIT` + `GUARD_CYCLES`. Go to WAIT.
- **WAIT:**
  - `transaction_length` = 0. The core retriggers on any nonzero length in its idle state, so length must be 0 in every state except ISSUE.
  - `transaction_data` and `transaction_rw_mask` hold their ISSUE values.
  - Decrement the counter each cycle. At 0, capture `rsp_rdata` = `rw` ? `transaction_read_data[REG_DATA_WIDTH-1:0]` : 0, set `rsp_valid`, and go to RESP.
- **RESP:**
  - Hold `rsp_valid`, `rsp_rdata` and `rsp_rw` stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`: clear `rsp_valid` and go to IDLE.
  - `rsp_ready` may already be high on the first RESP cycle.
- The wait counter is 16 bits. A static check asserts N < 2^16.
- No command queueing: exactly one transaction is outstanding. A command presented while busy stalls because `cmd_ready` = 0.
- When `cfg_error` = 1: `cmd_ready` stays 0 permanently and no transaction is ever issued.

## Timing
- **Reset values:** state IDLE; `cmd_ready` = !`cfg_error`; `rsp_valid` = 0; `rsp_rdata` = 0; `rsp_rw` = 0; `transaction_length` = 0; `transaction_data` = 0; `transaction_rw_mask` = 0; `busy` = 0; counter 0.
- **Latency:** command handshake at cycle T gives ISSUE at T+1 and WAIT for cycles T+2 .. T+N+1. `rsp_valid` is first high at T+N+2.
- **Turnaround:** a response handshake at cycle R gives `cmd_ready` = 1 at R+1. Minimum command-to-command spacing is N+3 cycles.
- **Reset mid-operation:** `reset` asserted in any state returns to IDLE with the reset values on the next edge. The in-flight response is discarded. No `transaction_length` pulse is issued after reset.

## Structure
- Shared package `spi_seq_pkg` holds:
  - `seq_state_t` enum (IDLE, ISSUE, WAIT, RESP), 2-bit logic.
  - `INSTR_WIDTH` = 8.
  - Function `seq_wait_cycles(L, CPB, GUARD)` returning N.
- Sub-module `spi_transaction_packer`: combinational builder of `transaction_data` and `transaction_rw_mask` from `{rw, addr, wdata}`, registered in the parent at ISSUE.
- Top level instantiates alongside `bidirectional_spi`: outputs to its transaction inputs, `transaction_read_data` from its output.

## Test plan
All scenarios use default parameters, so L = 24 and N = 224.
- **Write:** `cmd_rw`=0, `addr`=0x12, `wdata`=0xBEEF. Require at T+1: length = 24 for one cycle, data = 0x0012BEEF, mask = 0x00FFFFFF. Require at T+226: `rsp_valid`, `rsp_rdata` = 0, `rsp_rw` = 0.
- **Read:** `cmd_rw`=1, `addr`=0x05. Require data = 0x00850000 and mask = 0x00FF0000. With the core model returning 0x0000A5C3, require `rsp_rdata` = 0xA5C3 at T+226.
- **Backpressure:** `rsp_ready` = 0 for 10 cycles after `rsp_valid`. Response holds stable; `cmd_ready` = 0 throughout; IDLE is entered on the cycle after `rsp_ready` rises.
- **Back-to-back:** two commands with `cmd_valid` held. The second is accepted only after the first response handshake. Exactly two length pulses occur, 227 cycles apart with `rsp_ready` tied to 1.
- **Reset mid-WAIT:** `reset` at T+50. All outputs return to reset values, no `rsp_valid` appears, and a new command then completes normally.
- **Config error:** `REG_DATA_WIDTH`=32. Require `cfg_error` = 1 and `cmd_ready` = 0 forever, with `transaction_length` never nonzero.
